// File: rtl/dmem_dma_pkg.sv
// Shared definitions for the data-memory DMA copy engine: FSM states and
// the address stepping constants used by the engine and its address counters.
package dmem_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        READ,
        WRITE,
        DONE
    } dma_state_t;

    localparam logic [31:0] WORD_STEP       = 32'd4;
    localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/dma_addr_counter.sv
// Loadable word-address register: loads an aligned byte address and steps by
// one word when enabled, wrapping silently at 2^32.
module dma_addr_counter
    import dmem_dma_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        step,
    output logic [31:0] value
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_value & ADDR_ALIGN_MASK;
        end else if (step) begin
            value <= value + WORD_STEP;
        end
    end

endmodule

// File: rtl/dmem_dma_master.sv
// Bus-initiator copy engine on the CPU data-memory port: after winning the
// grant it alternates READ/WRITE cycles to copy len words from src to dst.
module dmem_dma_master
    import dmem_dma_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic [31:0]      addr,
    output logic [31:0]      datain,
    output logic             we,
    input  logic [31:0]      dataout,
    output logic             busy,
    output logic             done
);

    dma_state_t       state;
    logic [LEN_W-1:0] cnt;
    logic [31:0]      data_buf;
    logic [31:0]      src_cur;
    logic [31:0]      dst_cur;
    logic             accept;

    assign accept = (state == IDLE) && start;

    dma_addr_counter u_src_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (accept),
        .load_value (src_addr),
        .step       ((state == READ) && bus_gnt),
        .value      (src_cur)
    );

    dma_addr_counter u_dst_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (accept),
        .load_value (dst_addr),
        .step       ((state == WRITE) && bus_gnt),
        .value      (dst_cur)
    );

    // A missing grant freezes every register in place, so a stalled READ or
    // WRITE simply repeats on the next granted cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            data_buf <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= len;
                        state <= (len == '0) ? DONE : REQ;
                    end
                end
                REQ: begin
                    if (bus_gnt) state <= READ;
                end
                READ: begin
                    if (bus_gnt) begin
                        data_buf <= dataout;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (bus_gnt) begin
                        cnt   <= cnt - LEN_W'(1);
                        state <= (cnt == LEN_W'(1)) ? DONE : READ;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus_req = (state == REQ) || (state == READ) || (state == WRITE);
    assign busy    = bus_req;
    assign done    = (state == DONE);

    // Bus outputs are zero whenever the grant is absent so the arbiter can OR
    // the initiators together.
    always_comb begin
        addr   = '0;
        datain = '0;
        we     = 1'b0;
        if (bus_gnt) begin
            if (state == READ) begin
                addr = src_cur;
            end else if (state == WRITE) begin
                addr   = dst_cur;
                datain = data_buf;
                we     = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_dma_master.sv
// Self-checking bench for dmem_dma_master: a transfer-level model checks the
// bus every cycle, and directed tests pin timing and memory contents.
module tb_dmem_dma_master;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [7:0]  len = '0;
    logic        bus_gnt = 1'b0;
    logic        bus_req;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        we;
    logic [31:0] dataout;
    logic        busy;
    logic        done;

    always #5 clock = ~clock;

    dmem_dma_master #(.LEN_W(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .bus_req  (bus_req),
        .bus_gnt  (bus_gnt),
        .addr     (addr),
        .datain   (datain),
        .we       (we),
        .dataout  (dataout),
        .busy     (busy),
        .done     (done)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int edge0 = 0;
    int rel = 0;

    logic [31:0] ram [0:31];
    logic [31:0] in_port [0:3];
    logic [31:0] out_port [0:3];

    // Memory environment: bit 7 selects I/O ports, otherwise data RAM.
    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (a[7]) return in_port[a[3:2]];
        return ram[a[6:2]];
    endfunction

    always_comb dataout = addr[7] ? in_port[addr[3:2]] : ram[addr[6:2]];

    always @(negedge clock) begin
        if (we) begin
            if (addr[7]) out_port[addr[3:2]] <= datain;
            else         ram[addr[6:2]] <= datain;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h, expected %h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    // Transfer-level model: step -1 idle, 0 request, odd steps read word
    // (step-1)/2, even steps >= 2 write word step/2-1, 2*len+1 completion.
    int          m_step = -1;
    int          m_len = 0;
    int          k = 0;
    logic [31:0] m_src, m_dst, m_buf;
    logic [31:0] e_addr, e_data;
    logic        e_we, e_req, e_done, e_read;

    int done_count, done_rel, busy_count, busy_first, busy_last, req_count;
    int          wr_rel[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            m_step = -1;
        end else if (m_step < 0) begin
            if (start) begin
                m_src  = {src_addr[31:2], 2'b00};
                m_dst  = {dst_addr[31:2], 2'b00};
                m_len  = int'(len);
                m_step = (len == 0) ? 1 : 0;
            end
        end else if (m_step == 2 * m_len + 1) begin
            m_step = -1;
        end else if (bus_gnt) begin
            m_step++;
        end

        #3;
        if (reset) m_step = -1;
        e_req  = (m_step >= 0) && (m_step <= 2 * m_len);
        e_done = (m_step >= 0) && (m_step == 2 * m_len + 1);
        e_addr = '0;
        e_data = '0;
        e_we   = 1'b0;
        e_read = 1'b0;
        if (m_step >= 1 && m_step <= 2 * m_len && bus_gnt) begin
            if (m_step % 2 == 1) begin
                k      = (m_step - 1) / 2;
                e_addr = m_src + 32'(4 * k);
                e_read = 1'b1;
            end else begin
                k      = m_step / 2 - 1;
                e_addr = m_dst + 32'(4 * k);
                e_data = m_buf;
                e_we   = 1'b1;
            end
        end
        checkOutput("bus_req", {31'b0, bus_req}, {31'b0, e_req});
        checkOutput("busy",    {31'b0, busy},    {31'b0, e_req});
        checkOutput("done",    {31'b0, done},    {31'b0, e_done});
        checkOutput("we",      {31'b0, we},      {31'b0, e_we});
        checkOutput("addr",    addr,             e_addr);
        checkOutput("datain",  datain,           e_data);
        if (e_read) m_buf = mem_read(e_addr);

        rel = cyc - edge0 + 1;
        if (done) begin
            done_count++;
            done_rel = rel;
        end
        if (busy) begin
            if (busy_count == 0) busy_first = rel;
            busy_last = rel;
            busy_count++;
        end
        if (bus_req) req_count++;
        if (we) begin
            wr_rel.push_back(rel);
            wr_addr.push_back(addr);
            wr_data.push_back(datain);
        end
    end

    // Runs one transfer from the edge that samples start. glo..ghi is the
    // cycle window with the grant removed; restart_at and reset_at are -1
    // when unused.
    task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d,
                                 input logic [7:0] l, input int glo, input int ghi,
                                 input int restart_at, input int reset_at);
        int  r;
        bit  finished;
        @(posedge clock); #1;
        done_count = 0; done_rel = -1; busy_count = 0; busy_first = -1;
        busy_last = -1; req_count = 0;
        wr_rel.delete(); wr_addr.delete(); wr_data.delete();
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        len      = l;
        bus_gnt  = 1'b1;
        edge0    = cyc + 1;
        finished = 1'b0;
        for (int i = 0; i < 60 && !finished; i++) begin
            @(posedge clock); #1;
            r = cyc - edge0 + 1;
            start   = (restart_at >= 0) && (r == restart_at - 1);
            if (start) begin
                src_addr = 32'h0000_0044;
                dst_addr = 32'h0000_0074;
                len      = 8'd5;
            end
            bus_gnt = !(r >= glo && r <= ghi);
            if (reset_at >= 0 && r == reset_at) begin
                checkOutput("we_before_reset", {31'b0, we}, 32'd1);
                reset = 1'b1;
                #1;
                checkOutput("reset_bus_req", {31'b0, bus_req}, 32'd0);
                checkOutput("reset_we",      {31'b0, we},      32'd0);
                checkOutput("reset_addr",    addr,             32'd0);
                checkOutput("reset_datain",  datain,           32'd0);
                checkOutput("reset_busy",    {31'b0, busy},    32'd0);
            end else if (reset_at >= 0 && r == reset_at + 1) begin
                reset = 1'b0;
            end
            if (m_step == -1 && r >= 2 && !reset) finished = 1'b1;
        end
        checkOutput("transfer_completed", {31'b0, finished}, 32'd1);
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = '0;
        for (int i = 0; i < 4; i++) begin
            in_port[i]  = '0;
            out_port[i] = '0;
        end
        repeat (2) @(posedge clock);
        #2;
        checkOutput("reset_state_req",  {31'b0, bus_req}, 32'd0);
        checkOutput("reset_state_done", {31'b0, done},    32'd0);
        reset = 1'b0;

        $display("[TB] basic copy");
        ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33; ram[3] = 32'h44;
        applyStimulus(32'h00, 32'h20, 8'd3, 100, 0, -1, -1);
        checkOutput("basic_done_rel",   done_rel,   32'd8);
        checkOutput("basic_done_count", done_count, 32'd1);
        checkOutput("basic_busy_first", busy_first, 32'd1);
        checkOutput("basic_busy_last",  busy_last,  32'd7);
        checkOutput("basic_wr_count",   wr_rel.size(), 32'd3);
        if (wr_rel.size() == 3) begin
            checkOutput("basic_wr0_cycle", wr_rel[0], 32'd3);
            checkOutput("basic_wr1_cycle", wr_rel[1], 32'd5);
            checkOutput("basic_wr2_cycle", wr_rel[2], 32'd7);
            checkOutput("basic_wr0_addr",  wr_addr[0], 32'h20);
            checkOutput("basic_wr2_addr",  wr_addr[2], 32'h28);
            checkOutput("basic_wr1_data",  wr_data[1], 32'h22);
        end
        checkOutput("basic_ram8",  ram[8],  32'h11);
        checkOutput("basic_ram9",  ram[9],  32'h22);
        checkOutput("basic_ram10", ram[10], 32'h33);

        $display("[TB] zero length");
        applyStimulus(32'h00, 32'h40, 8'd0, 100, 0, -1, -1);
        checkOutput("zero_done_rel",   done_rel,   32'd1);
        checkOutput("zero_done_count", done_count, 32'd1);
        checkOutput("zero_busy",       busy_count, 32'd0);
        checkOutput("zero_req",        req_count,  32'd0);
        checkOutput("zero_writes",     wr_rel.size(), 32'd0);

        $display("[TB] grant drop");
        ram[16] = 32'hA5A5_0001; ram[17] = 32'hA5A5_0002;
        applyStimulus(32'h40, 32'h50, 8'd2, 3, 4, -1, -1);
        checkOutput("gnt_done_rel", done_rel, 32'd8);
        checkOutput("gnt_wr_count", wr_rel.size(), 32'd2);
        if (wr_rel.size() == 2) begin
            checkOutput("gnt_wr0_cycle", wr_rel[0], 32'd5);
            checkOutput("gnt_wr1_cycle", wr_rel[1], 32'd7);
        end
        checkOutput("gnt_ram20", ram[20], 32'hA5A5_0001);
        checkOutput("gnt_ram21", ram[21], 32'hA5A5_0002);

        $display("[TB] io to ram");
        in_port[0] = 32'hDEAD_BEEF;
        applyStimulus(32'h83, 32'h10, 8'd1, 100, 0, -1, -1);
        checkOutput("io_ram4",     ram[4],   32'hDEAD_BEEF);
        checkOutput("io_done_rel", done_rel, 32'd4);

        $display("[TB] restart ignored");
        applyStimulus(32'h00, 32'h30, 8'd3, 100, 0, 3, -1);
        checkOutput("restart_done_count", done_count, 32'd1);
        checkOutput("restart_done_rel",   done_rel,   32'd8);
        checkOutput("restart_wr_count",   wr_rel.size(), 32'd3);
        if (wr_rel.size() == 3) checkOutput("restart_wr2_addr", wr_addr[2], 32'h38);
        checkOutput("restart_ram14", ram[14], 32'h33);
        checkOutput("restart_ram29", ram[29], 32'h0);

        $display("[TB] reset mid-transfer");
        ram[25] = 32'hCAFE;
        applyStimulus(32'h00, 32'h60, 8'd4, 100, 0, -1, 5);
        checkOutput("rst_done_count", done_count, 32'd0);
        checkOutput("rst_ram24",      ram[24],    32'h11);
        checkOutput("rst_ram25",      ram[25],    32'hCAFE);
        applyStimulus(32'h00, 32'h60, 8'd4, 100, 0, -1, -1);
        checkOutput("rerun_done_rel", done_rel, 32'd10);
        checkOutput("rerun_ram25",    ram[25],  32'h22);
        checkOutput("rerun_ram27",    ram[27],  32'h44);

        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
